// File: rtl/compressor_reduce_seq.sv
// Multi-beat 8-operand reduction sequencer: an 8:2 carry-save compressor feeds a register stage,
// then a CPA plus accumulate stage. The file also holds the 8:2 compressor it instantiates.

module compressor_8_2_n_bit #(
    parameter int unsigned N            = 12,
    parameter int unsigned OUTPUT_WIDTH = 15,
    parameter int unsigned SHIFT_CARRY  = 1
) (
    input  logic                    is_signed_i,
    input  logic [N-1:0]            op_i [8],
    output logic [OUTPUT_WIDTH-1:0] sum_o,
    output logic [OUTPUT_WIDTH-1:0] carry_o
);
    localparam int unsigned OW = OUTPUT_WIDTH;

    logic [OW-1:0] ext [8];
    logic [OW-1:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, maj6;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            ext[k] = {{(OW-N){is_signed_i & op_i[k][N-1]}}, op_i[k]};
        end
    end

    // Full-adder layer; interior carries are shifted into weight position as they are formed.
    always_comb begin
        s1   = ext[0] ^ ext[1] ^ ext[2];
        c1   = ((ext[0] & ext[1]) | (ext[0] & ext[2]) | (ext[1] & ext[2])) << 1;
        s2   = ext[3] ^ ext[4] ^ ext[5];
        c2   = ((ext[3] & ext[4]) | (ext[3] & ext[5]) | (ext[4] & ext[5])) << 1;
        s3   = s1 ^ c1 ^ s2;
        c3   = ((s1 & c1) | (s1 & s2) | (c1 & s2)) << 1;
        s4   = c2 ^ ext[6] ^ ext[7];
        c4   = ((c2 & ext[6]) | (c2 & ext[7]) | (ext[6] & ext[7])) << 1;
        s5   = s3 ^ c3 ^ s4;
        c5   = ((s3 & c3) | (s3 & s4) | (c3 & s4)) << 1;
        s6   = s5 ^ c5 ^ c4;
        maj6 = (s5 & c5) | (s5 & c4) | (c5 & c4);
    end

    assign sum_o   = s6;
    assign carry_o = (SHIFT_CARRY != 0) ? (maj6 << 1) : maj6;

endmodule

module compressor_reduce_seq #(
    parameter int unsigned INPUT_WIDTH = 12,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned MAX_BEATS   = 256,
    parameter int unsigned BEAT_W      = $clog2(MAX_BEATS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [BEAT_W-1:0]      cfg_beats_i,
    input  logic                   cfg_signed_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [INPUT_WIDTH-1:0] in_data_i [8],
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [ACC_WIDTH-1:0]   res_data_o,
    output logic                   busy_o
);
    localparam int unsigned OUT_W = INPUT_WIDTH + 3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [BEAT_W-1:0]    cnt_q, cnt_d;
    logic                 signed_q, signed_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]     s1_sum_q, s1_sum_d;
    logic [OUT_W-1:0]     s1_carry_q, s1_carry_d;

    logic [OUT_W-1:0]     comp_sum, comp_carry;
    logic [OUT_W-1:0]     beat_val;
    logic [ACC_WIDTH-1:0] beat_ext;
    logic                 in_hs;

    compressor_8_2_n_bit #(
        .N            (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUT_W),
        .SHIFT_CARRY  (1)
    ) u_comp (
        .is_signed_i (signed_q),
        .op_i        (in_data_i),
        .sum_o       (comp_sum),
        .carry_o     (comp_carry)
    );

    assign cfg_ready_o = (state_q == StIdle);
    assign in_ready_o  = (state_q == StAccum);
    assign res_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign res_data_o  = res_valid_o ? acc_q : '0;
    assign in_hs       = in_valid_i & in_ready_o;

    // The OUT_W-bit sum is exact for 8 operands, so extension by the job signedness is lossless.
    assign beat_val = s1_sum_q + s1_carry_q;

    always_comb begin
        for (int i = 0; i < int'(ACC_WIDTH); i++) begin
            if (i < int'(OUT_W)) begin
                beat_ext[i] = beat_val[i];
            end else begin
                beat_ext[i] = signed_q & beat_val[OUT_W-1];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        signed_d   = signed_q;
        acc_d      = acc_q;
        s1_valid_d = in_hs;
        s1_sum_d   = s1_sum_q;
        s1_carry_d = s1_carry_q;

        if (s1_valid_q) begin
            acc_d = acc_q + beat_ext;
        end

        case (state_q)
            StIdle: begin
                if (cfg_valid_i) begin
                    state_d  = StAccum;
                    cnt_d    = cfg_beats_i;
                    signed_d = cfg_signed_i;
                    acc_d    = '0;
                end
            end
            StAccum: begin
                if (in_valid_i) begin
                    s1_sum_d   = comp_sum;
                    s1_carry_d = comp_carry;
                    // Counter holds at zero on the last beat instead of wrapping.
                    if (cnt_q == '0) begin
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q - BEAT_W'(1);
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_carry_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            signed_q   <= signed_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_carry_q <= s1_carry_d;
        end
    end

endmodule
